pm_load_arbiter: RTL and testbench
==================================

# pm_load_arbiter

Owns the program-memory port between the program sequencer's fetch address and a host loader that streams instruction words into program memory. After reset it holds the CPU in sequencer reset, writes the incoming image sequentially from address 0, then releases the CPU to fetch from the same port. A debug request re-enters load mode at a chosen start address, so code can be patched without a full system reset.

## Interface
Parameters:
- ADDR_W, 8, program-memory address width; matches the sequencer's `pm_addr`.
- DATA_W, 8, instruction word width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ld_valid  in  1  host word valid.
- ld_ready  out  1  block accepts a word; a word transfers when `ld_valid && ld_ready` at a clk edge.
- ld_data  in  DATA_W  instruction word.
- ld_last  in  1  qualifies the final word of an image.
- dbg_req  in  1  request to halt the CPU and reload.
- dbg_addr  in  ADDR_W  start write address for a debug reload.
- cpu_pm_addr  in  ADDR_W  fetch address from the program sequencer.
- cpu_hold  out  1  drives the sequencer's `sync_reset`.
- pm_addr  out  ADDR_W  program-memory address.
- pm_wdata  out  DATA_W  program-memory write data.
- pm_we  out  1  program-memory write enable.
- load_cnt  out  ADDR_W+1  words accepted in the current or most recent load.
- ovf  out  1  sticky flag: a load wrapped the address space without `ld_last`.
- chksum  out  DATA_W  running checksum (see Configuration).

## Operation
- States: LOAD, START, RUN.
- Reset values: state=LOAD, wr_ptr=0, load_cnt=0, ovf=0, chksum=0.
- Outputs per state:
  - LOAD: cpu_hold=1, ld_ready=1, pm_addr=wr_ptr, pm_wdata=ld_data, pm_we=ld_valid.
  - START: cpu_hold=1, ld_ready=0, pm_we=0, pm_addr=cpu_pm_addr.
  - RUN: cpu_hold=0, ld_ready=0, pm_we=0, pm_addr=cpu_pm_addr.
- LOAD, accepted beat:
  - wr_ptr increments modulo 2^ADDR_W; load_cnt increments.
  - If `ld_last`, go to START.
  - Else if wr_ptr = 2^ADDR_W−1, the word is still written, ovf is set, and the block goes to START.
  - If `ld_last` and wrap occur on the same beat, `ld_last` wins and ovf is not set.
- START: unconditionally goes to RUN after one cycle. This guarantees the sequencer samples `sync_reset`=1, so its `pc` registers 0 before release.
- RUN: if `dbg_req`=1 at an edge, go to LOAD with wr_ptr←dbg_addr and load_cnt←0. ovf is kept; it clears only on reset.
- `dbg_req` is ignored in LOAD and START.
- An idle host (`ld_valid`=0) in LOAD keeps the CPU held indefinitely.
- Asserting reset_n low in any state returns to reset values immediately; a partially written image is not invalidated.

## Timing
- pm_addr, pm_wdata, pm_we and ld_ready are combinational from the state register and inputs. The memory write occurs at the same edge as the handshake, giving zero-cycle write latency.
- cpu_hold, wr_ptr, load_cnt, ovf and chksum are decoded from, or are, registers.
- After the edge accepting `ld_last`, cpu_hold is 1 for exactly one full cycle (START) and falls after the second edge.
- The first RUN cycle presents cpu_pm_addr=0 from the sequencer.
- From a `dbg_req` edge, cpu_hold=1 is visible in the next cycle. Any fetch in flight is discarded because the sequencer restarts at 0.
- Throughput in LOAD is one word per cycle.

## Configuration
- `PM_LOAD_CHECKSUM_EN` defined:
  - chksum resets to 0 on reset and on each entry to LOAD from RUN.
  - Each accepted word updates chksum ← chksum + ld_data, modulo 2^DATA_W.
- Not defined: chksum is tied to 0 and no adder is instantiated.

## Structure
- Package `pm_ctrl_pkg` holds:
  - the state enum (LOAD, START, RUN);
  - ADDR_W and DATA_W default constants;
  - the localparam for the last address, 2^ADDR_W−1.
- One sub-module, `pm_load_counter`, contains:
  - wr_ptr and load_cnt, with increment, load-from-dbg_addr and wrap detect;
  - a `wrap` output asserted when the increment-enable is high and wr_ptr is at the last address.
- The top level holds the FSM, the port mux and the checksum.

## Test plan
- Reset, then stream 4 words 0x11, 0x22, 0x33, 0x44 with `ld_last` on 0x44:
  - writes land at addresses 0–3 with pm_we=1;
  - load_cnt=4, ovf=0;
  - cpu_hold falls 2 edges after the last beat;
  - with the macro defined, chksum=0xAA.
- Stream 256 words with no `ld_last`:
  - the last write is at 0xFF;
  - ovf=1, load_cnt=256, and the block transitions to RUN.
- In RUN with cpu_pm_addr=0x05, pulse `dbg_req` with dbg_addr=0x40 and send 2 words, the last one with `ld_last`:
  - writes go to 0x40 and 0x41;
  - load_cnt=2;
  - after release, pm_addr follows cpu_pm_addr starting at 0x00.
- Hold `ld_valid`=0 for 50 cycles after reset:
  - cpu_hold stays 1 and pm_we stays 0;
  - `dbg_req` pulses have no effect.
- Send 255 words, with the 256th carrying `ld_last` at address 0xFF:
  - ovf=0, and the block goes to START.
- Assert reset_n low mid-load after 3 words:
  - state returns to LOAD with wr_ptr=0, load_cnt=0, ovf=0 and cpu_hold=1 immediately.

Source files
------------

// File: rtl/pm_ctrl_pkg.sv
// Shared definitions for the program-memory load arbiter.
// Contents: FSM state encoding, default address/data widths, and the
// last-address constant used for wrap detection at the default width.
package pm_ctrl_pkg;

  localparam int unsigned PM_ADDR_W = 8;
  localparam int unsigned PM_DATA_W = 8;

  // Highest program-memory address at the default width (2^PM_ADDR_W - 1).
  localparam logic [PM_ADDR_W-1:0] PM_LAST_ADDR = '1;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } pm_state_t;

endpackage

// File: rtl/pm_load_counter.sv
// Write-pointer and word counter for program-memory loads.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   inc_en         : an accepted load beat; advances wr_ptr and load_cnt
//   load_en        : restart a load at load_addr with load_cnt cleared
//   load_addr      : start address for a restarted load
//   wr_ptr         : current program-memory write address
//   load_cnt       : words accepted in the current/most recent load
//   wrap           : inc_en while wr_ptr sits at the last address
module pm_load_counter
  import pm_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = PM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inc_en,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W:0]   load_cnt,
  output logic              wrap
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   load_cnt_q, load_cnt_d;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    load_cnt_d = load_cnt_q;
    if (load_en) begin
      wr_ptr_d   = load_addr;
      load_cnt_d = '0;
    end else if (inc_en) begin
      // Pointer wraps naturally modulo 2^ADDR_W.
      wr_ptr_d   = wr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      load_cnt_d = load_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      load_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      load_cnt_q <= load_cnt_d;
    end
  end

  assign wr_ptr   = wr_ptr_q;
  assign load_cnt = load_cnt_q;
  assign wrap     = inc_en && (wr_ptr_q == LAST_ADDR);

endmodule

// File: rtl/pm_load_arbiter.sv
// Program-memory port arbiter between a host image loader and the program
// sequencer. Holds the CPU in sequencer reset while an image is streamed in
// from address 0, releases it after one START cycle, and re-enters load mode
// at dbg_addr on a debug request from RUN.
// Optional feature: define PM_LOAD_CHECKSUM_EN to enable the running
// additive checksum of accepted words; otherwise chksum is tied to 0.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   ld_valid/ld_ready     : host word handshake (ld_data, ld_last)
//   dbg_req, dbg_addr     : reload request and its start address
//   cpu_pm_addr           : sequencer fetch address
//   cpu_hold              : sequencer sync_reset (registered)
//   pm_addr/pm_wdata/pm_we: program-memory port (combinational)
//   load_cnt, ovf, chksum : load status
module pm_load_arbiter
  import pm_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = PM_ADDR_W,
  parameter int unsigned DATA_W = PM_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [ADDR_W-1:0] cpu_pm_addr,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [DATA_W-1:0] pm_wdata,
  output logic              pm_we,
  output logic [ADDR_W:0]   load_cnt,
  output logic              ovf,
  output logic [DATA_W-1:0] chksum
);

  pm_state_t         state_q;
  logic              cpu_hold_q;
  logic              ovf_q;
  logic              in_load;
  logic              accept;
  logic              reload;
  logic              wrap;
  logic [ADDR_W-1:0] wr_ptr;

  assign in_load = (state_q == ST_LOAD);
  assign accept  = in_load && ld_valid;
  assign reload  = (state_q == ST_RUN) && dbg_req;

  pm_load_counter #(
    .ADDR_W(ADDR_W)
  ) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc_en   (accept),
    .load_en  (reload),
    .load_addr(dbg_addr),
    .wr_ptr   (wr_ptr),
    .load_cnt (load_cnt),
    .wrap     (wrap)
  );

  // cpu_hold is registered with the state so it is high in LOAD and START.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_LOAD;
      cpu_hold_q <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept && (ld_last || wrap)) begin
            state_q <= ST_START;
            // ld_last on the wrapping beat is a complete image, not overflow.
            if (!ld_last) ovf_q <= 1'b1;
          end
          cpu_hold_q <= 1'b1;
        end
        ST_START: begin
          state_q    <= ST_RUN;
          cpu_hold_q <= 1'b0;
        end
        ST_RUN: begin
          if (dbg_req) begin
            state_q    <= ST_LOAD;
            cpu_hold_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_LOAD;
          cpu_hold_q <= 1'b1;
        end
      endcase
    end
  end

  assign cpu_hold = cpu_hold_q;
  assign ovf      = ovf_q;
  assign ld_ready = in_load;
  assign pm_we    = accept;
  assign pm_addr  = in_load ? wr_ptr : cpu_pm_addr;
  assign pm_wdata = in_load ? ld_data : '0;

`ifdef PM_LOAD_CHECKSUM_EN
  logic [DATA_W-1:0] chk_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chk_q <= '0;
    end else if (reload) begin
      chk_q <= '0;
    end else if (accept) begin
      chk_q <= chk_q + ld_data;
    end
  end

  assign chksum = chk_q;
`else
  assign chksum = '0;
`endif

endmodule

// File: tb/tb_pm_load_arbiter.sv
// Self-checking bench for pm_load_arbiter. Expected memory writes are queued
// when a word is driven and compared by a negedge monitor when pm_we fires.
module tb_pm_load_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [DW-1:0] ld_data = '0;
  logic          ld_last = 1'b0;
  logic          dbg_req = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [AW-1:0] cpu_pm_addr = '0;
  logic          cpu_hold;
  logic [AW-1:0] pm_addr;
  logic [DW-1:0] pm_wdata;
  logic          pm_we;
  logic [AW:0]   load_cnt;
  logic          ovf;
  logic [DW-1:0] chksum;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] sum_exp = '0;

  pm_load_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .dbg_req    (dbg_req),
    .dbg_addr   (dbg_addr),
    .cpu_pm_addr(cpu_pm_addr),
    .cpu_hold   (cpu_hold),
    .pm_addr    (pm_addr),
    .pm_wdata   (pm_wdata),
    .pm_we      (pm_we),
    .load_cnt   (load_cnt),
    .ovf        (ovf),
    .chksum     (chksum)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] exp_chk();
`ifdef PM_LOAD_CHECKSUM_EN
    return sum_exp;
`else
    return '0;
`endif
  endfunction

  // Write monitor: every pm_we pulse must match the oldest queued write.
  always @(negedge clk) begin
    wr_t e;
    if (reset_n && pm_we) begin
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_write addr=%h data=%h", pm_addr, pm_wdata);
      end else begin
        e = exp_q.pop_front();
        if (pm_addr !== e.addr || pm_wdata !== e.data) begin
          bad = bad + 1;
          $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                   pm_addr, pm_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic do_reset();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    dbg_req  = 1'b0;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    sum_exp = '0;
    exp_q.delete();
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last, input logic [AW-1:0] a);
    wr_t e;
    @(posedge clk); #1;
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
    sum_exp = sum_exp + d;
  endtask

  // The edge inside this task accepts the final driven word.
  task automatic end_stream();
    @(posedge clk); #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic pulse_dbg(input logic [AW-1:0] a);
    @(posedge clk); #1;
    dbg_req  = 1'b1;
    dbg_addr = a;
    @(posedge clk); #1;
    dbg_req  = 1'b0;
    sum_exp  = '0;
  endtask

  task automatic drain_check(input string name);
    #5;
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL %s writes_pending got=%0d want=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total = total + 6;
    if (cpu_hold !== 1'b1) begin bad++; $display("FAIL reset cpu_hold got=%b want=1", cpu_hold); end
    if (ld_ready !== 1'b1) begin bad++; $display("FAIL reset ld_ready got=%b want=1", ld_ready); end
    if (load_cnt !== '0) begin bad++; $display("FAIL reset load_cnt got=%0d want=0", load_cnt); end
    if (ovf !== 1'b0) begin bad++; $display("FAIL reset ovf got=%b want=0", ovf); end
    if (pm_addr !== '0) begin bad++; $display("FAIL reset pm_addr got=%h want=00", pm_addr); end
    if (chksum !== '0) begin bad++; $display("FAIL reset chksum got=%h want=00", chksum); end
  endtask

  task automatic test_basic();
    send(8'h11, 1'b0, 8'h00);
    send(8'h22, 1'b0, 8'h01);
    send(8'h33, 1'b0, 8'h02);
    send(8'h44, 1'b1, 8'h03);
    end_stream();
    // Now in START.
    cpu_pm_addr = 8'h77;
    #1;
    total = total + 7;
    if (cpu_hold !== 1'b1) begin bad++; $display("FAIL basic start_hold got=%b want=1", cpu_hold); end
    if (ld_ready !== 1'b0) begin bad++; $display("FAIL basic start_ready got=%b want=0", ld_ready); end
    if (pm_addr !== 8'h77) begin bad++; $display("FAIL basic start_pm_addr got=%h want=77", pm_addr); end
    if (load_cnt !== 9'd4) begin bad++; $display("FAIL basic load_cnt got=%0d want=4", load_cnt); end
    if (ovf !== 1'b0) begin bad++; $display("FAIL basic ovf got=%b want=0", ovf); end
    if (exp_chk() !== 8'hAA && exp_chk() !== 8'h00) begin bad++; $display("FAIL basic model_sum got=%h want=AA", sum_exp); end
    if (chksum !== exp_chk()) begin bad++; $display("FAIL basic chksum got=%h want=%h", chksum, exp_chk()); end
    @(posedge clk); #1;
    total = total + 1;
    if (cpu_hold !== 1'b0) begin bad++; $display("FAIL basic release got=%b want=0", cpu_hold); end
    drain_check("basic");
  endtask

  task automatic test_wrap_ovf();
    do_reset();
    for (int i = 0; i < 256; i++) send(8'(i) ^ 8'h5A, 1'b0, 8'(i));
    end_stream();
    total = total + 5;
    if (ovf !== 1'b1) begin bad++; $display("FAIL wrap ovf got=%b want=1", ovf); end
    if (load_cnt !== 9'd256) begin bad++; $display("FAIL wrap load_cnt got=%0d want=256", load_cnt); end
    if (cpu_hold !== 1'b1) begin bad++; $display("FAIL wrap start_hold got=%b want=1", cpu_hold); end
    if (ld_ready !== 1'b0) begin bad++; $display("FAIL wrap start_ready got=%b want=0", ld_ready); end
    if (chksum !== exp_chk()) begin bad++; $display("FAIL wrap chksum got=%h want=%h", chksum, exp_chk()); end
    @(posedge clk); #1;
    total = total + 1;
    if (cpu_hold !== 1'b0) begin bad++; $display("FAIL wrap run got=%b want=0", cpu_hold); end
    drain_check("wrap");
  endtask

  task automatic test_dbg_reload();
    cpu_pm_addr = 8'h05;
    #1;
    total = total + 1;
    if (pm_addr !== 8'h05) begin bad++; $display("FAIL dbg run_pm_addr got=%h want=05", pm_addr); end
    pulse_dbg(8'h40);
    total = total + 6;
    if (cpu_hold !== 1'b1) begin bad++; $display("FAIL dbg hold got=%b want=1", cpu_hold); end
    if (ld_ready !== 1'b1) begin bad++; $display("FAIL dbg ready got=%b want=1", ld_ready); end
    if (load_cnt !== '0) begin bad++; $display("FAIL dbg load_cnt_clr got=%0d want=0", load_cnt); end
    if (ovf !== 1'b1) begin bad++; $display("FAIL dbg ovf_kept got=%b want=1", ovf); end
    if (pm_addr !== 8'h40) begin bad++; $display("FAIL dbg start_addr got=%h want=40", pm_addr); end
    if (chksum !== '0) begin bad++; $display("FAIL dbg chksum_clr got=%h want=00", chksum); end
    send(8'hA5, 1'b0, 8'h40);
    send(8'h5A, 1'b1, 8'h41);
    end_stream();
    cpu_pm_addr = 8'h00;
    total = total + 2;
    if (load_cnt !== 9'd2) begin bad++; $display("FAIL dbg load_cnt got=%0d want=2", load_cnt); end
    if (chksum !== exp_chk()) begin bad++; $display("FAIL dbg chksum got=%h want=%h", chksum, exp_chk()); end
    @(posedge clk); #1;
    total = total + 2;
    if (cpu_hold !== 1'b0) begin bad++; $display("FAIL dbg release got=%b want=0", cpu_hold); end
    if (pm_addr !== 8'h00) begin bad++; $display("FAIL dbg first_fetch got=%h want=00", pm_addr); end
    cpu_pm_addr = 8'h01;
    #1;
    total = total + 1;
    if (pm_addr !== 8'h01) begin bad++; $display("FAIL dbg follow got=%h want=01", pm_addr); end
    drain_check("dbg");
  endtask

  task automatic test_reset_midload();
    pulse_dbg(8'h10);
    send(8'h01, 1'b0, 8'h10);
    send(8'h02, 1'b0, 8'h11);
    send(8'h03, 1'b0, 8'h12);
    end_stream();
    total = total + 1;
    if (load_cnt !== 9'd3) begin bad++; $display("FAIL midrst pre_cnt got=%0d want=3", load_cnt); end
    #2 reset_n = 1'b0;
    #1;
    total = total + 6;
    if (cpu_hold !== 1'b1) begin bad++; $display("FAIL midrst hold got=%b want=1", cpu_hold); end
    if (ld_ready !== 1'b1) begin bad++; $display("FAIL midrst ready got=%b want=1", ld_ready); end
    if (load_cnt !== '0) begin bad++; $display("FAIL midrst load_cnt got=%0d want=0", load_cnt); end
    if (ovf !== 1'b0) begin bad++; $display("FAIL midrst ovf got=%b want=0", ovf); end
    if (pm_addr !== 8'h00) begin bad++; $display("FAIL midrst wr_ptr got=%h want=00", pm_addr); end
    if (chksum !== '0) begin bad++; $display("FAIL midrst chksum got=%h want=00", chksum); end
    @(negedge clk) reset_n = 1'b1;
    sum_exp = '0;
    send(8'hC3, 1'b1, 8'h00);
    end_stream();
    total = total + 1;
    if (load_cnt !== 9'd1) begin bad++; $display("FAIL midrst post_cnt got=%0d want=1", load_cnt); end
    drain_check("midrst");
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      dbg_req  = (i % 10 == 3);
      dbg_addr = 8'h80;
      @(negedge clk);
      total = total + 2;
      if (cpu_hold !== 1'b1) begin bad++; $display("FAIL idle hold cyc=%0d got=%b want=1", i, cpu_hold); end
      if (pm_we !== 1'b0) begin bad++; $display("FAIL idle we cyc=%0d got=%b want=0", i, pm_we); end
    end
    dbg_req = 1'b0;
    send(8'h99, 1'b1, 8'h00);
    end_stream();
    total = total + 2;
    if (load_cnt !== 9'd1) begin bad++; $display("FAIL idle load_cnt got=%0d want=1", load_cnt); end
    if (ld_ready !== 1'b0) begin bad++; $display("FAIL idle start_ready got=%b want=0", ld_ready); end
    drain_check("idle");
  endtask

  task automatic test_last_at_wrap();
    do_reset();
    for (int i = 0; i < 255; i++) send(8'(i), 1'b0, 8'(i));
    send(8'hEE, 1'b1, 8'hFF);
    end_stream();
    total = total + 5;
    if (ovf !== 1'b0) begin bad++; $display("FAIL lastwrap ovf got=%b want=0", ovf); end
    if (load_cnt !== 9'd256) begin bad++; $display("FAIL lastwrap load_cnt got=%0d want=256", load_cnt); end
    if (cpu_hold !== 1'b1) begin bad++; $display("FAIL lastwrap hold got=%b want=1", cpu_hold); end
    if (ld_ready !== 1'b0) begin bad++; $display("FAIL lastwrap ready got=%b want=0", ld_ready); end
    if (chksum !== exp_chk()) begin bad++; $display("FAIL lastwrap chksum got=%h want=%h", chksum, exp_chk()); end
    @(posedge clk); #1;
    total = total + 1;
    if (cpu_hold !== 1'b0) begin bad++; $display("FAIL lastwrap run got=%b want=0", cpu_hold); end
    drain_check("lastwrap");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap_ovf();
    test_dbg_reload();
    test_reset_midload();
    test_idle();
    test_last_at_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
